// File: rtl/walking_bit_checker.sv
// walking_bit_checker: receive-side checker for the walking-one pattern.
// Locks onto a one-hot progression, then flags and counts deviations.
//
// Ports:
//   i_clk        - clock
//   i_rst_n      - async active-low reset
//   i_clear      - sync clear of counters and sticky flag
//   i_valid      - i_data holds a word to check
//   i_data       - received word, 2**WIDTH bits
//   o_locked     - high while locked onto the sequence
//   o_error      - one-cycle pulse per bad word while locked
//   o_sticky_err - set on any error, held until clear/reset
//   o_err_count  - saturating error count
//   o_word_count - wrapping count of words checked while locked
//   o_expected   - bit index expected in the next word
module walking_bit_checker #(
   parameter int WIDTH      = 5,
   parameter int CNT_W      = 32,
   parameter int LOCK_WORDS = 4,
   parameter int LOSS_WORDS = 4
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_clear,
   input  logic                  i_valid,
   input  logic [2**WIDTH-1:0]   i_data,
   output logic                  o_locked,
   output logic                  o_error,
   output logic                  o_sticky_err,
   output logic [CNT_W-1:0]      o_err_count,
   output logic [CNT_W-1:0]      o_word_count,
   output logic [WIDTH-1:0]      o_expected
);

   localparam int DW = 2**WIDTH;

   localparam logic [DW-1:0]    ONE     = DW'(1);
   localparam logic [7:0]       LOCK_N  = 8'(LOCK_WORDS);
   localparam logic [7:0]       LOSS_N  = 8'(LOSS_WORDS);
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [WIDTH-1:0] IDX_ONE = WIDTH'(1);

   typedef enum logic {
      SEARCH,
      LOCKED
   } state_t;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   exp_q, exp_d;
   logic [7:0]         run_q, run_d;
   logic [7:0]         miss_q, miss_d;
   logic               err_q, err_d;
   logic               sticky_q, sticky_d;
   logic [CNT_W-1:0]   errc_q, errc_d;
   logic [CNT_W-1:0]   wc_q, wc_d;

   logic               onehot;
   logic [WIDTH-1:0]   idx;
   logic               match;

   // x & (x-1) clears the lowest set bit; zero result means at most one bit.
   assign onehot = (i_data != '0) &&
                   ((i_data & (i_data - ONE)) == '0);

   // Index of the set bit; only meaningful when onehot is true.
   always_comb begin
      idx = '0;
      for (int i = 0; i < DW; i++) begin
         if (i_data[i]) begin
            idx = WIDTH'(i);
         end
      end
   end

   assign match = (i_data == (ONE << exp_q));

   always_comb begin
      state_d  = state_q;
      exp_d    = exp_q;
      run_d    = run_q;
      miss_d   = miss_q;
      err_d    = 1'b0;
      sticky_d = sticky_q;
      errc_d   = errc_q;
      wc_d     = wc_q;

      if (i_valid) begin
         unique case (state_q)
            SEARCH: begin
               if (match && (run_q != 8'd0)) begin
                  run_d = run_q + 8'd1;
                  exp_d = exp_q + IDX_ONE;
                  if ((run_q + 8'd1) == LOCK_N) begin
                     state_d = LOCKED;
                     miss_d  = 8'd0;
                  end
               end else if (onehot) begin
                  // Reseed on any one-hot word that breaks the run.
                  exp_d = idx + IDX_ONE;
                  run_d = 8'd1;
                  if (LOCK_WORDS == 1) begin
                     state_d = LOCKED;
                     miss_d  = 8'd0;
                  end
               end else begin
                  run_d = 8'd0;
               end
            end
            LOCKED: begin
               // Advance regardless of match so one bad word
               // costs exactly one error.
               exp_d = exp_q + IDX_ONE;
               wc_d  = wc_q + CNT_ONE;
               if (match) begin
                  miss_d = 8'd0;
               end else begin
                  err_d    = 1'b1;
                  sticky_d = 1'b1;
                  miss_d   = miss_q + 8'd1;
                  if (errc_q != CNT_MAX) begin
                     errc_d = errc_q + CNT_ONE;
                  end
                  if ((miss_q + 8'd1) == LOSS_N) begin
                     state_d = SEARCH;
                     run_d   = 8'd0;
                  end
               end
            end
            default: begin
               state_d = SEARCH;
            end
         endcase
      end

      // Clear wins over any same-cycle update of the statistics.
      if (i_clear) begin
         errc_d   = '0;
         wc_d     = '0;
         sticky_d = 1'b0;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q  <= SEARCH;
         exp_q    <= '0;
         run_q    <= '0;
         miss_q   <= '0;
         err_q    <= 1'b0;
         sticky_q <= 1'b0;
         errc_q   <= '0;
         wc_q     <= '0;
      end else begin
         state_q  <= state_d;
         exp_q    <= exp_d;
         run_q    <= run_d;
         miss_q   <= miss_d;
         err_q    <= err_d;
         sticky_q <= sticky_d;
         errc_q   <= errc_d;
         wc_q     <= wc_d;
      end
   end

   assign o_locked     = (state_q == LOCKED);
   assign o_error      = err_q;
   assign o_sticky_err = sticky_q;
   assign o_err_count  = errc_q;
   assign o_word_count = wc_q;
   assign o_expected   = exp_q;

endmodule

// File: tb/tb_walking_bit_checker.sv
// tb_walking_bit_checker: directed bench for walking_bit_checker.
// Two instances (default, and CNT_W=4/LOSS_WORDS=255) share stimulus.
module tb_walking_bit_checker;

   logic        clk;
   logic        rst_n;
   logic        clear;
   logic        valid;
   logic [31:0] data;

   logic        lk0, er0, st0;
   logic [31:0] ec0, wc0;
   logic [4:0]  ex0;
   logic        lk1, er1, st1;
   logic [3:0]  ec1, wc1;
   logic [4:0]  ex1;

   int n_chk;
   int n_fail;

   walking_bit_checker dut0 (
      .i_clk        (clk),
      .i_rst_n      (rst_n),
      .i_clear      (clear),
      .i_valid      (valid),
      .i_data       (data),
      .o_locked     (lk0),
      .o_error      (er0),
      .o_sticky_err (st0),
      .o_err_count  (ec0),
      .o_word_count (wc0),
      .o_expected   (ex0)
   );

   walking_bit_checker #(
      .CNT_W      (4),
      .LOSS_WORDS (255)
   ) dut1 (
      .i_clk        (clk),
      .i_rst_n      (rst_n),
      .i_clear      (clear),
      .i_valid      (valid),
      .i_data       (data),
      .o_locked     (lk1),
      .o_error      (er1),
      .o_sticky_err (st1),
      .o_err_count  (ec1),
      .o_word_count (wc1),
      .o_expected   (ex1)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Behavioural model: per instance, spec-level rules on plain integers.
   longint m_exp  [2] = '{0, 0};
   longint m_run  [2] = '{0, 0};
   longint m_miss [2] = '{0, 0};
   longint m_errc [2] = '{0, 0};
   longint m_wc   [2] = '{0, 0};
   bit     m_lk   [2] = '{0, 0};
   bit     m_err  [2] = '{0, 0};
   bit     m_st   [2] = '{0, 0};
   longint cmax   [2] = '{64'hFFFF_FFFF, 64'd15};
   longint cmod   [2] = '{64'h1_0000_0000, 64'd16};
   longint lossw  [2] = '{64'd4, 64'd255};
   localparam longint LOCKW = 4;

   task automatic step(input int k);
      longint pos;
      bit     is1;
      bit     hit;
      m_err[k] = 1'b0;
      if (valid) begin
         is1 = ($countones(data) == 1);
         pos = 0;
         for (int i = 0; i < 32; i++) if (data[i]) pos = i;
         hit = (data == (32'd1 << m_exp[k]));
         if (!m_lk[k]) begin
            if (hit && m_run[k] > 0) begin
               m_run[k]++;
               m_exp[k] = (m_exp[k] + 1) % 32;
               if (m_run[k] == LOCKW) begin
                  m_lk[k]   = 1'b1;
                  m_miss[k] = 0;
               end
            end else if (is1) begin
               m_exp[k] = (pos + 1) % 32;
               m_run[k] = 1;
            end else begin
               m_run[k] = 0;
            end
         end else begin
            m_exp[k] = (m_exp[k] + 1) % 32;
            m_wc[k]  = (m_wc[k] + 1) % cmod[k];
            if (hit) begin
               m_miss[k] = 0;
            end else begin
               m_err[k]  = 1'b1;
               m_st[k]   = 1'b1;
               m_errc[k] = (m_errc[k] + 1 > cmax[k]) ?
                           cmax[k] : m_errc[k] + 1;
               m_miss[k]++;
               if (m_miss[k] == lossw[k]) begin
                  m_lk[k]  = 1'b0;
                  m_run[k] = 0;
               end
            end
         end
      end
      if (clear) begin
         m_errc[k] = 0;
         m_wc[k]   = 0;
         m_st[k]   = 1'b0;
      end
   endtask

   initial forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
         for (int k = 0; k < 2; k++) begin
            m_exp[k] = 0; m_run[k] = 0; m_miss[k] = 0;
            m_errc[k] = 0; m_wc[k] = 0;
            m_lk[k] = 0; m_err[k] = 0; m_st[k] = 0;
         end
      end else begin
         step(0);
         step(1);
      end
   end

   task automatic chk(input string nm,
                      input logic [63:0] act,
                      input logic [63:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, want %0h (t=%0t)",
                  nm, act, req, $time);
      end
   endtask

   // Compare both instances against the model on every falling edge.
   initial forever begin
      @(negedge clk);
      chk("d0.locked", 64'(lk0), 64'(m_lk[0]));
      chk("d0.error",  64'(er0), 64'(m_err[0]));
      chk("d0.sticky", 64'(st0), 64'(m_st[0]));
      chk("d0.errcnt", 64'(ec0), m_errc[0]);
      chk("d0.wrdcnt", 64'(wc0), m_wc[0]);
      chk("d0.expect", 64'(ex0), m_exp[0]);
      chk("d1.locked", 64'(lk1), 64'(m_lk[1]));
      chk("d1.error",  64'(er1), 64'(m_err[1]));
      chk("d1.sticky", 64'(st1), 64'(m_st[1]));
      chk("d1.errcnt", 64'(ec1), m_errc[1]);
      chk("d1.wrdcnt", 64'(wc1), m_wc[1]);
      chk("d1.expect", 64'(ex1), m_exp[1]);
   end

   // Drive one word; returns 1ns after the sampling edge.
   task automatic word(input logic [31:0] d, input logic clr);
      valid = 1'b1;
      data  = d;
      clear = clr;
      @(posedge clk);
      #1;
      valid = 1'b0;
      clear = 1'b0;
      data  = 32'h0;
   endtask

   task automatic bit_word(input int b);
      word(32'd1 << b, 1'b0);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      idle(1);
      rst_n = 1'b1;
   endtask

   int e;

   initial begin
      n_chk  = 0;
      n_fail = 0;
      rst_n  = 1'b0;
      clear  = 1'b0;
      valid  = 1'b0;
      data   = 32'h0;
      idle(2);
      rst_n = 1'b1;
      idle(1);

      // Lock on an earlier stream, then reset mid-lock.
      for (int b = 3; b <= 7; b++) bit_word(b);
      chk("pre.locked", 64'(lk0), 64'd1);
      rst_n = 1'b0;
      #1;
      chk("rst.locked", 64'(lk0), 64'd0);
      chk("rst.expect", 64'(ex0), 64'd0);
      chk("rst.wrdcnt", 64'(wc0), 64'd0);
      chk("rst.error",  64'(er0), 64'd0);
      idle(1);
      rst_n = 1'b1;

      // Acquisition.
      bit_word(7);
      bit_word(8);
      bit_word(9);
      chk("acq.early", 64'(lk0), 64'd0);
      bit_word(10);
      chk("acq.locked", 64'(lk0), 64'd1);
      chk("acq.expect", 64'(ex0), 64'd11);
      chk("acq.errcnt", 64'(ec0), 64'd0);
      chk("acq.wrdcnt", 64'(wc0), 64'd0);

      // Walk up to index 30 and zero the counters.
      for (int b = 11; b <= 29; b++) bit_word(b);
      clear = 1'b1;
      idle(1);
      clear = 1'b0;
      chk("clr.wrdcnt", 64'(wc0), 64'd0);

      // Wrap-around with idle gaps.
      bit_word(30); idle(0);
      bit_word(31); idle(1);
      bit_word(0);  idle(2);
      bit_word(1);  idle(3);
      chk("wrap.errcnt", 64'(ec0), 64'd0);
      chk("wrap.wrdcnt", 64'(wc0), 64'd4);
      chk("wrap.expect", 64'(ex0), 64'd2);

      // Single corruption at index 12.
      for (int b = 2; b <= 11; b++) bit_word(b);
      word(32'h0000_1001, 1'b0);
      chk("cor.error",  64'(er0), 64'd1);
      chk("cor.errcnt", 64'(ec0), 64'd1);
      chk("cor.sticky", 64'(st0), 64'd1);
      chk("cor.locked", 64'(lk0), 64'd1);
      bit_word(13);
      chk("cor.next",   64'(er0), 64'd0);

      // Loss after four bad words, then reacquire.
      clear = 1'b1;
      idle(1);
      clear = 1'b0;
      for (int i = 0; i < 4; i++) begin
         word(32'h0, 1'b0);
         chk("loss.error", 64'(er0), 64'd1);
         if (i < 3) chk("loss.held", 64'(lk0), 64'd1);
      end
      chk("loss.locked", 64'(lk0), 64'd0);
      chk("loss.errcnt", 64'(ec0), 64'd4);
      for (int b = 20; b <= 22; b++) bit_word(b);
      chk("rel.early", 64'(lk0), 64'd0);
      bit_word(23);
      chk("rel.locked", 64'(lk0), 64'd1);
      chk("rel.error",  64'(er0), 64'd0);
      chk("rel.errcnt", 64'(ec0), 64'd4);

      // Clear on the same cycle as a bad word.
      word(32'h0, 1'b1);
      chk("cp.error",  64'(er0), 64'd1);
      chk("cp.errcnt", 64'(ec0), 64'd0);
      chk("cp.wrdcnt", 64'(wc0), 64'd0);
      chk("cp.sticky", 64'(st0), 64'd0);
      chk("cp.locked", 64'(lk0), 64'd1);
      bit_word(25);

      // Saturation / wrap on the narrow instance.
      do_reset();
      for (int b = 0; b <= 3; b++) bit_word(b);
      chk("sat.acq", 64'(lk1), 64'd1);
      e = 4;
      for (int i = 0; i < 36; i++) begin
         if (i % 2 == 0) bit_word((e + 5) % 32);
         else            bit_word(e);
         e = (e + 1) % 32;
         chk("sat.held", 64'(lk1), 64'd1);
      end
      chk("sat.errcnt",  64'(ec1), 64'd15);
      chk("sat.wrdcnt",  64'(wc1), 64'd4);
      chk("sat.sticky",  64'(st1), 64'd1);
      chk("sat.d0err",   64'(ec0), 64'd18);
      chk("sat.d0wc",    64'(wc0), 64'd36);
      idle(2);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
